// File: rtl/shift_sequencer_pkg.sv
// Shared op and state encodings for the shift sequencer.
// The core control FSM also uses the op encodings.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int STEP_W = 3;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/busy/done handshake bundle between core control and shifter.
// master = core control, slave = shift_sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);

  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result
  );

endinterface

// File: rtl/shift_sequencer_shift_step.sv
// One combinational shift step of 1, 2 or 4 bits for SLL/SRL/SRA.
// shl2 is the fixed left-by-2 block used for the common 2-bit step.
module shl2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] shifted
);

  assign shifted = {value[WIDTH-3:0], 2'b00};

endmodule

module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  value,
  input  op_e               op,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  stepped
);

  logic             fill;
  logic [WIDTH-1:0] left2;

  assign fill = (op == OP_SRA) & value[WIDTH-1];

  shl2 #(.WIDTH(WIDTH)) u_shl2 (
    .value  (value),
    .shifted(left2)
  );

  // Select the stepped value by direction and step size.
  always_comb begin
    stepped = value;
    unique case (op)
      OP_SLL: begin
        unique case (1'b1)
          step[2]: stepped = value << 4;
          step[1]: stepped = left2;
          default: stepped = value << 1;
        endcase
      end
      OP_SRL, OP_SRA: begin
        unique case (1'b1)
          step[2]: stepped = {{4{fill}}, value[WIDTH-1:4]};
          step[1]: stepped = {{2{fill}}, value[WIDTH-1:2]};
          default: stepped = {fill, value[WIDTH-1:1]};
        endcase
      end
      default: stepped = value;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller stepping 2/1 bits per cycle.
// Define SHIFT_SEQ_STEP4_EN to also take 4-bit steps.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  shift_sequencer_if.slave bus
);

  state_e             state;
  state_e             state_n;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] rem_dec;
  op_e                op_q;
  logic [STEP_W-1:0]  step;
  logic [WIDTH-1:0]   stepped;
  logic               accept;
  logic               skip;

  assign accept = (state == IDLE) && bus.start;
  assign skip   = (bus.shamt == '0) ||
                  (op_e'(bus.op) == OP_RSVD);

  // Largest step that does not overshoot the remaining count.
  always_comb begin
    step = STEP_W'(1);
`ifdef SHIFT_SEQ_STEP4_EN
    if (rem_q >= SHAMT_W'(4))
      step = STEP_W'(4);
    else if (rem_q >= SHAMT_W'(2))
      step = STEP_W'(2);
`else
    if (rem_q >= SHAMT_W'(2))
      step = STEP_W'(2);
`endif
  end

  assign rem_dec = rem_q - SHAMT_W'(step);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (result_q),
    .op     (op_q),
    .step   (step),
    .stepped(stepped)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_n = skip ? DONE : SHIFT;
      end
      SHIFT: begin
        if (rem_dec == '0)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand load on accept, then one step per SHIFT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= OP_SLL;
    end else if (accept) begin
      result_q <= bus.data_in;
      rem_q    <= bus.shamt;
      op_q     <= op_e'(bus.op);
    end else if (state == SHIFT) begin
      result_q <= stepped;
      rem_q    <= rem_dec;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer.
// Randomized and directed ops against a behavioural model.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(
    input logic [1:0] o, input logic [31:0] d, input int s);
    logic [31:0] r;
    case (o)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int model_lat(
    input logic [1:0] o, input int s);
    int extra [4];
    extra = '{0, 1, 1, 2};
    if (s == 0 || o == 2'b11) return 1;
`ifdef SHIFT_SEQ_STEP4_EN
    return 1 + s / 4 + extra[s % 4];
`else
    return 1 + (s + 1) / 2;
`endif
  endfunction

  // Issue one op, wait for done, return latency, result and next-cycle flags.
  task automatic do_op(
    input  logic [1:0]  o,
    input  logic [31:0] d,
    input  logic [4:0]  s,
    output int          lat,
    output logic [31:0] r,
    output logic        nxt_done,
    output logic        nxt_busy);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.data_in = d;
    bus.shamt   = s;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom);
    bus.op      = 2'($urandom);
    while (!bus.done && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = bus.result;
    @(negedge clk);
    nxt_done = bus.done;
    nxt_busy = bus.busy;
  endtask

  task automatic test_reset;
    int lat;
    logic [31:0] r;
    logic nd, nb;
    reset = 1'b1;
    #12;
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL reset_result got=%h want=0", bus.result);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    do_op(2'b00, 32'd10, 5'd2, lat, r, nd, nb);
    checks++;
    if (r !== 32'd40) begin
      failures++;
      $display("FAIL first_sll got=%0d want=40", r);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL first_lat got=%0d want=2", lat);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [9];
    logic [31:0] t_d  [9];
    logic [4:0]  t_s  [9];
    logic [31:0] t_r  [9];
    int lat;
    logic [31:0] r;
    logic nd, nb;
    t_op = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10,
             2'b10, 2'b00, 2'b11, 2'b01};
    t_d  = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000,
             32'h80000000, 32'h7FFFFFF0, 32'hF0000000,
             32'h12345678, 32'hCAFEBABE, 32'hFFFFFFFF};
    t_s  = '{5'd2, 5'd31, 5'd31, 5'd31, 5'd4,
             5'd3, 5'd0, 5'd5, 5'd1};
    t_r  = '{32'hFFFFFFFC, 32'h80000000, 32'h00000001,
             32'hFFFFFFFF, 32'h07FFFFFF, 32'hFE000000,
             32'h12345678, 32'hCAFEBABE, 32'h7FFFFFFF};
    for (int i = 0; i < 9; i++) begin
      do_op(t_op[i], t_d[i], t_s[i], lat, r, nd, nb);
      checks++;
      if (r !== t_r[i]) begin
        failures++;
        $display("FAIL dir_res[%0d] got=%h want=%h", i, r, t_r[i]);
      end
      checks++;
      if (lat !== model_lat(t_op[i], int'(t_s[i]))) begin
        failures++;
        $display("FAIL dir_lat[%0d] got=%0d want=%0d",
                 i, lat, model_lat(t_op[i], int'(t_s[i])));
      end
    end
    do_op(2'b00, 32'h1, 5'd31, lat, r, nd, nb);
    checks++;
`ifdef SHIFT_SEQ_STEP4_EN
    if (lat !== 10) begin
      failures++;
      $display("FAIL lat31 got=%0d want=10", lat);
    end
`else
    if (lat !== 17) begin
      failures++;
      $display("FAIL lat31 got=%0d want=17", lat);
    end
`endif
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] er;
    int lat;
    logic [31:0] r;
    logic nd, nb;
    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom_range(0, 3));
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      er = model_res(o, d, int'(s));
      do_op(o, d, s, lat, r, nd, nb);
      checks++;
      if (r !== er) begin
        failures++;
        $display("FAIL rnd_res op=%0d d=%h s=%0d got=%h want=%h",
                 o, d, s, r, er);
      end
      checks++;
      if (lat !== model_lat(o, int'(s))) begin
        failures++;
        $display("FAIL rnd_lat op=%0d s=%0d got=%0d want=%0d",
                 o, s, lat, model_lat(o, int'(s)));
      end
      checks++;
      if (nd !== 1'b0 || nb !== 1'b0) begin
        failures++;
        $display("FAIL rnd_idle done=%b busy=%b want=0/0", nd, nb);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int pulses;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h1;
    bus.shamt   = 5'd31;
    @(posedge clk);
    lat = 1;
    pulses = 0;
    @(negedge clk);
    bus.op      = 2'b01;
    bus.data_in = 32'hA5A5A5A5;
    bus.shamt   = 5'd3;
    while (!bus.done && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (bus.result !== 32'h80000000) begin
      failures++;
      $display("FAIL b2b_first got=%h want=80000000", bus.result);
    end
    checks++;
    if (lat !== model_lat(2'b00, 31)) begin
      failures++;
      $display("FAIL b2b_lat got=%0d want=%0d",
               lat, model_lat(2'b00, 31));
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b done=%b want=0/0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.result !== 32'h80000000) begin
      failures++;
      $display("FAIL b2b_hold got=%h want=80000000", bus.result);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.result !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL b2b_accept busy=%b res=%h want=1/a5a5a5a5",
               bus.busy, bus.result);
    end
    lat = 1;
    while (lat < 64) begin
      if (bus.done) pulses++;
      if (!bus.busy) break;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d want=1", pulses);
    end
    checks++;
    if (bus.result !== model_res(2'b01, 32'hA5A5A5A5, 3)) begin
      failures++;
      $display("FAIL b2b_second got=%h want=%h", bus.result,
               model_res(2'b01, 32'hA5A5A5A5, 3));
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses;
    logic [31:0] r;
    logic nd, nb;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h1;
    bus.shamt   = 5'd31;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset busy=%b res=%h want=0/0",
               bus.busy, bus.result);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL mid_nodone got=%0d want=0", pulses);
    end
    do_op(2'b00, 32'h3, 5'd5, lat, r, nd, nb);
    checks++;
    if (r !== 32'h60 || lat !== model_lat(2'b00, 5)) begin
      failures++;
      $display("FAIL mid_after res=%h lat=%0d want=60/%0d",
               r, lat, model_lat(2'b00, 5));
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.data_in = '0;
    bus.shamt   = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for a shift-by-2 / shift-by-1 step datapath. It implements the MIPS SLL, SRL and SRA operations for any shamt in 0..31.
It steps an internal operand register 2 bits per cycle while 2 or more bits remain, and 1 bit for the final odd bit.
It sits beside the ALU in the multi-cycle core. The core's control FSM starts it with a start/busy/done handshake and stalls until done.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; shamt range 0..2^SHAMT_W-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (result=data_in, shamt ignored)
data_in  input  WIDTH  operand, captured on accepted start
shamt  input  SHAMT_W  shift amount, captured on accepted start
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  registered operand value; holds until next accepted start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset (any time, including mid-operation): state=IDLE, result=0, remaining=0, op_q=0, busy=0, done=0. Any in-flight operation is abandoned.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - result<=data_in, remaining<=shamt, op_q<=op.
  - If shamt==0 or op==11, go to DONE; otherwise go to SHIFT.
- SHIFT, each edge:
  - step=2 if remaining>=2, else 1.
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with result[WIDTH-1].
  - remaining<=remaining-step. When the new remaining==0, go to DONE.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start-sample edge to the edge after which done is high = 1 edge for shamt=0, else 1+ceil(shamt/2). shamt=31 gives 17.
- start while busy is ignored and not queued. start in the DONE cycle is ignored. It is accepted on the following IDLE cycle, so the back-to-back minimum issue interval is latency+1.
- data_in, shamt and op may change freely after acceptance; only the captured copies are used.
- result is not cleared on accept until the load edge. It is stable from done until the next accepted start.
- Widths: remaining is SHAMT_W bits and never underflows, because step≤remaining is guaranteed. Bits shifted out are discarded; no overflow or carry flag.

Optional Feature:
Macro SHIFT_SEQ_STEP4_EN.
- Defined: SHIFT uses step=4 while remaining>=4, then 2, then 1. Latency = 1 + floor(shamt/4) + {0,1,1,2}[shamt mod 4]; shamt=31 gives 10.
- Undefined: steps of 2/1 only, as above. Results are identical in both builds; only latency differs.

Decomposition:
- Shared package/include: op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_RSVD=2'b11) and state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2). The core control FSM also uses the op encodings.
- One natural sub-module, shift_step: combinational, inputs value, op, step; output the stepped value. It instantiates the existing shift-by-2 block for the left-by-2 path. The FSM, counter and registers stay in shift_sequencer.

Test Plan:
- Reset while idle: reset=1 -> result=0, busy=0, done=0. Then SLL data_in=10, shamt=2 -> done one cycle after the single SHIFT edge, result=40, latency=2.
- SLL 0xFFFFFFFF, shamt=2 -> result 0xFFFFFFFC. SLL 0x00000001, shamt=31 -> 0x80000000, latency 17 (10 with SHIFT_SEQ_STEP4_EN).
- SRL 0x80000000, shamt=31 -> 0x00000001. SRA 0x80000000, shamt=31 -> 0xFFFFFFFF. SRA 0x7FFFFFF0, shamt=4 -> 0x07FFFFFF. Odd shamt=3 with SRA on 0xF0000000 -> 0xFE000000.
- shamt=0 and op=11: SLL 0x12345678, shamt=0 -> done after 1 edge, result 0x12345678. op=11, shamt=5 -> result=data_in, latency 1.
- Handshake: pulse start again during SHIFT and DONE with different data_in -> ignored. First result unchanged, done pulses exactly once, busy deasserts for one IDLE cycle before the next accept.
- Reset mid-operation: assert reset asynchronously at cycle 3 of a shamt=31 SLL -> busy=0, result=0 immediately. No done pulse. A new start after reset release completes normally.
